// File: rtl/dff_write_arb.sv
// dff_write_arb: four-requester round-robin arbiter that writes one shared 4-bit register.
// Each request edge produces a registered one-hot grant, the winner's data, the winner's
// index and a one-cycle valid strobe. The round-robin pointer always moves past the last winner.
// Optional grant locking is compiled in by defining DFF_ARB_LOCK_EN. With locking, an owner
// holding lock is re-granted for up to four consecutive cycles, after which one normal
// arbitration is forced.
module dff_write_arb (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [15:0] d_in,
  input  logic [3:0]  lock,
  output logic [3:0]  gnt,
  output logic [3:0]  q,
  output logic        valid,
  output logic [1:0]  owner
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t     state;
  logic [1:0] ptr;
  logic [1:0] winner;
  logic [1:0] cand;
  logic       found;
  logic       any_req;
  logic       hold;

  function automatic logic [3:0] onehot(input logic [1:0] idx);
    onehot = 4'b0001 << idx;
  endfunction

  function automatic logic [3:0] slice_of(input logic [15:0] data, input logic [1:0] idx);
    slice_of = data[{idx, 2'b00} +: 4];
  endfunction

  // Pick the first requester at or after ptr, wrapping modulo 4
  always_comb begin
    winner  = ptr;
    cand    = ptr;
    found   = 1'b0;
    any_req = |req;
    for (int k = 0; k < 4; k++) begin
      cand = ptr + 2'(k);
      if (!found && req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

`ifdef DFF_ARB_LOCK_EN
  logic [1:0] lock_cnt;

  // The owner keeps the register while it requests with lock, unless its run of grants just wrapped
  assign hold = (state != IDLE) && req[owner] && lock[owner] && (lock_cnt != 2'd0);
`else
  logic lock_unused;

  assign lock_unused = ^lock;
  assign hold        = 1'b0;
`endif

  // Arbitration state machine with registered grant, data, owner and valid
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      ptr      <= 2'd0;
      gnt      <= 4'd0;
      q        <= 4'd0;
      valid    <= 1'b0;
      owner    <= 2'd0;
`ifdef DFF_ARB_LOCK_EN
      lock_cnt <= 2'd0;
`endif
    end else if (hold) begin
      gnt      <= onehot(owner);
      q        <= slice_of(d_in, owner);
      valid    <= 1'b1;
      state    <= LOCKED;
`ifdef DFF_ARB_LOCK_EN
      lock_cnt <= lock_cnt + 2'd1;
`endif
    end else if (any_req) begin
      gnt      <= onehot(winner);
      q        <= slice_of(d_in, winner);
      owner    <= winner;
      valid    <= 1'b1;
      ptr      <= winner + 2'd1;
      state    <= GRANT;
`ifdef DFF_ARB_LOCK_EN
      if ((state == IDLE) || (winner != owner)) begin
        lock_cnt <= 2'd1;
      end else begin
        lock_cnt <= lock_cnt + 2'd1;
      end
`endif
    end else begin
      gnt      <= 4'd0;
      valid    <= 1'b0;
      state    <= IDLE;
`ifdef DFF_ARB_LOCK_EN
      lock_cnt <= 2'd0;
`endif
    end
  end

endmodule

// File: doc/dff_write_arb.md
DFF_WRITE_ARB -- requirements
Module: dff_write_arb

Interface
REQ-001 The block SHALL have parameters: none; all widths are fixed (4 requesters, 4-bit data).
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset; rst=0 SHALL clear all state immediately, independent of clk.
REQ-004 req  input  4  per-requester write request, bit i = requester i.
REQ-005 d_in  input  16  requester data, requester i on bits [4i+3:4i].
REQ-006 lock  input  4  per-requester hold request; SHALL only take effect when DFF_ARB_LOCK_EN is defined, otherwise the port exists and is ignored.
REQ-007 gnt  output  4  registered one-hot grant, all-zero when idle.
REQ-008 q  output  4  shared 4-bit register, last granted data.
REQ-009 valid  output  1  high for the cycle after a write is accepted.
REQ-010 owner  output  2  index of the last granted requester.

Function
REQ-011 The block SHALL hold a 2-bit round-robin pointer ptr and a state machine with states IDLE, GRANT, LOCKED.
REQ-012 Winner selection SHALL pick the first i with req[i]=1, searching ptr, ptr+1, ... with wrap modulo 4.
REQ-013 On a clock edge with any req set (and not LOCKED): gnt <= onehot(winner), q <= d_in slice of winner, owner <= winner, valid <= 1, ptr <= (winner+1) mod 4, state <= GRANT.
REQ-014 On a clock edge with req=0: gnt <= 0, valid <= 0, q and owner hold, ptr holds, state <= IDLE.
REQ-015 Latency SHALL be exactly one cycle from req sampled high to gnt/q/valid visible.
REQ-016 gnt SHALL never have more than one bit set; gnt[owner]=1 whenever valid=1.
REQ-017 A requester held high continuously SHALL be granted at most once every cycle and at least once every 4 cycles when others also request (no starvation).
REQ-018 Pointer wrap: winner=3 SHALL set ptr=0.
REQ-019 All four requests simultaneous with ptr=2 SHALL grant order 2,3,0,1 on successive cycles.
REQ-020 Deasserting req of the current owner SHALL release the grant at the next edge with no extra idle cycle if another req is pending.

Reset
REQ-021 While rst=0: gnt=0, valid=0, q=0, owner=0, ptr=0, state=IDLE, lock counter=0.
REQ-022 Reset asserted mid-transfer SHALL abort it; first edge after release SHALL arbitrate from ptr=0.

Configuration
REQ-023 Macro DFF_ARB_LOCK_EN SHALL compile in grant locking; undefined, the block SHALL behave exactly as REQ-011..REQ-020 and state LOCKED SHALL be unreachable.
REQ-024 With DFF_ARB_LOCK_EN: if in GRANT or LOCKED and req[owner]=1 and lock[owner]=1, next edge SHALL re-grant owner, reload q from its data, hold ptr, state <= LOCKED, increment 2-bit lock counter.
REQ-025 With DFF_ARB_LOCK_EN: after 4 consecutive granted cycles of one owner (counter wraps to 0), lock SHALL be ignored for one arbitration, normal round-robin applies, counter cleared on any owner change or IDLE.

Verification
REQ-026 rst=0 pulse at 1 ns, req=0 -> gnt=0, valid=0, q=0, owner=0 during and after reset.
REQ-027 req=4'b0010, d_in[7:4]=4'hA for one cycle -> next edge gnt=4'b0010, q=4'hA, owner=1, valid=1; following edge gnt=0, valid=0, q=4'hA.
REQ-028 After reset req=4'b1111 for 5 cycles, distinct data per requester -> owner sequence 0,1,2,3,0, q tracks matching slice each cycle.
REQ-029 req=4'b1111, rst=0 asserted between edges at cycle 3 -> outputs clear immediately; after release owner sequence restarts at 0.
REQ-030 DFF_ARB_LOCK_EN defined, req=4'b0011, lock=4'b0001 for 6 cycles -> owner 0,0,0,0,1,0; undefined -> owner 0,1,0,1,0,1.
REQ-031 Random req/d_in for 1000 cycles vs. reference model -> gnt one-hot, q equals winner data, no requester waits more than 4 cycles (lock off).
